// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall vectors, multi-cycle type codes and FSM encodings for pipe_stall_ctrl.
package pipe_stall_ctrl_pkg;
    typedef logic [5:0] stall_t;
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam logic [1:0] MC_NONE = 2'b00;
    localparam logic [1:0] MC_MADD = 2'b01;
    localparam logic [1:0] MC_DIV  = 2'b10;
    localparam logic [1:0] MC_DIVU = 2'b11;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    function automatic stall_t id_stall(input logic req);
        return req ? STALL_ID : STALL_NONE;
    endfunction
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: core-side request/response bundle of pipe_stall_ctrl.
// PIPE_STALL_PERF_EN adds the two stall-cycle performance counters.
interface pipe_stall_ctrl_if import pipe_stall_ctrl_pkg::*; #(parameter int CNT_W = 6);
    logic             stallreq_id_i;
    logic             ex_mc_start_i;
    logic [1:0]       ex_mc_type_i;
    logic             ex_mc_cancel_i;
    logic             flush_req_i;
    logic [31:0]      flush_pc_i;
    stall_t           stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             ex_mc_done_o;
    logic [CNT_W-1:0] ex_mc_cnt_o;
    logic             busy_o;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0]      perf_id_stall_o;
    logic [31:0]      perf_mc_stall_o;
    modport slave (
        input  stallreq_id_i, ex_mc_start_i, ex_mc_type_i, ex_mc_cancel_i, flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, ex_mc_done_o, ex_mc_cnt_o, busy_o,
        output perf_id_stall_o, perf_mc_stall_o
    );
    modport master (
        output stallreq_id_i, ex_mc_start_i, ex_mc_type_i, ex_mc_cancel_i, flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, ex_mc_done_o, ex_mc_cnt_o, busy_o,
        input  perf_id_stall_o, perf_mc_stall_o
    );
`else
    modport slave (
        input  stallreq_id_i, ex_mc_start_i, ex_mc_type_i, ex_mc_cancel_i, flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, ex_mc_done_o, ex_mc_cnt_o, busy_o
    );
    modport master (
        output stallreq_id_i, ex_mc_start_i, ex_mc_type_i, ex_mc_cancel_i, flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, ex_mc_done_o, ex_mc_cnt_o, busy_o
    );
`endif
endinterface

// File: rtl/pipe_stall_ctrl_mc_cycle_counter.sv
// mc_cycle_counter: loadable up-counter with terminal-count compare against a latched length N.
module mc_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] n_in,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    logic [CNT_W-1:0] n_lat;
    // load starts at 1: the start cycle itself is iteration 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            n_lat <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt   <= CNT_W'(1);
            n_lat <= n_in;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
    assign tc = cnt == n_lat - CNT_W'(1);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use stalls, multi-cycle EX ops and flushes into one stall vector.
// PIPE_STALL_PERF_EN adds saturating ID/EX stall-cycle counters.
module pipe_stall_ctrl import pipe_stall_ctrl_pkg::*; #(
    parameter int MADD_CYCLES = 2,
    parameter int DIV_CYCLES  = 34,
    parameter int CNT_W       = 6
) (
    input logic               clk,
    input logic               rst,
    pipe_stall_ctrl_if.slave  bus
);
    logic [0:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, n_sel;
    logic             is_run, start_ok, flush, tc, load, en, clr, release_op;
    stall_t           stall;
    assign is_run   = state == ST_RUN;
    assign flush    = bus.flush_req_i;
    assign start_ok = bus.ex_mc_start_i && bus.ex_mc_type_i != MC_NONE;
    assign n_sel    = bus.ex_mc_type_i == MC_MADD ? CNT_W'(MADD_CYCLES) : CNT_W'(DIV_CYCLES);
    always_comb begin
        release_op = is_run && (bus.ex_mc_cancel_i || tc);
        load       = !flush && !is_run && start_ok;
        en         = !flush && is_run && !release_op;
        clr        = flush || release_op;
        state_nx   = load || en ? ST_RUN : ST_IDLE;
        stall      = flush ? STALL_NONE : load || en ? STALL_EX : id_stall(bus.stallreq_id_i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nx;
    end
    mc_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .load (load),
        .en   (en),
        .n_in (n_sel),
        .cnt  (cnt),
        .tc   (tc)
    );
    always_comb begin
        bus.stall_o      = stall;
        bus.flush_o      = flush;
        bus.new_pc_o     = flush ? bus.flush_pc_i : 32'h0;
        bus.ex_mc_done_o = !flush && is_run && tc && !bus.ex_mc_cancel_i;
        bus.busy_o       = !flush && (is_run || start_ok);
        bus.ex_mc_cnt_o  = cnt;
    end
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_id, perf_mc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_id <= '0;
            perf_mc <= '0;
        end else if (!flush) begin
            if (stall == STALL_ID && ~&perf_id) perf_id <= perf_id + 32'd1;
            if (stall == STALL_EX && ~&perf_mc) perf_mc <= perf_mc + 32'd1;
        end
    end
    assign bus.perf_id_stall_o = perf_id;
    assign bus.perf_mc_stall_o = perf_mc;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed plus random stimulus, expectations queued by an op-level model.
module tb_pipe_stall_ctrl;
    localparam int MADD = 2;
    localparam int DIV  = 34;
    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        logic [5:0]  cnt;
        logic        busy;
        logic [31:0] pid;
        logic [31:0] pmc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pipe_stall_ctrl_if #(.CNT_W(6)) bus();
    pipe_stall_ctrl #(.MADD_CYCLES(MADD), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    exp_t q[$];
    exp_t m;
    int total = 0;
    int bad = 0;
    bit act = 0;
    int len = 0;
    int age = 0;
    int pid = 0;
    int pmc = 0;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, got, want, $time);
        end
    endtask
    // One clock of stimulus; the model works in terms of "op of length N, age k".
    task automatic cycle(input bit req, input bit st, input logic [1:0] ty, input bit can, input bit fl, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.stallreq_id_i  = req;
        bus.ex_mc_start_i  = st;
        bus.ex_mc_type_i   = ty;
        bus.ex_mc_cancel_i = can;
        bus.flush_req_i    = fl;
        bus.flush_pc_i     = pc;
        e.pid = pid;
        e.pmc = pmc;
        e.flush = 0;
        e.pc = 0;
        e.done = 0;
        e.cnt = act ? 6'(age) : 6'd0;
        if (fl) begin
            e.flush = 1;
            e.pc = pc;
            e.stall = 6'h00;
            e.busy = 0;
            act = 0;
        end else if (!act) begin
            if (st && ty != 2'b00) begin
                e.stall = 6'h0F;
                e.busy = 1;
                act = 1;
                len = (ty == 2'b01) ? MADD : DIV;
                age = 1;
            end else begin
                e.stall = req ? 6'h07 : 6'h00;
                e.busy = 0;
            end
        end else begin
            e.busy = 1;
            if (can || age == len - 1) begin
                e.stall = req ? 6'h07 : 6'h00;
                e.done = !can;
                act = 0;
            end else begin
                e.stall = 6'h0F;
                age++;
            end
        end
        if (!fl) begin
            if (e.stall == 6'h07) pid++;
            if (e.stall == 6'h0F) pmc++;
        end
        q.push_back(e);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 2'b00, 0, 0, 32'h0);
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("stall", 32'(bus.stall_o), 32'(m.stall));
            chk("flush", 32'(bus.flush_o), 32'(m.flush));
            chk("new_pc", bus.new_pc_o, m.pc);
            chk("done", 32'(bus.ex_mc_done_o), 32'(m.done));
            chk("cnt", 32'(bus.ex_mc_cnt_o), 32'(m.cnt));
            chk("busy", 32'(bus.busy_o), 32'(m.busy));
`ifdef PIPE_STALL_PERF_EN
            chk("perf_id", bus.perf_id_stall_o, m.pid);
            chk("perf_mc", bus.perf_mc_stall_o, m.pmc);
`endif
        end
    end
    initial begin
        bus.stallreq_id_i  = 0;
        bus.ex_mc_start_i  = 0;
        bus.ex_mc_type_i   = 2'b00;
        bus.ex_mc_cancel_i = 0;
        bus.flush_req_i    = 0;
        bus.flush_pc_i     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'({bus.stall_o, bus.flush_o, bus.ex_mc_done_o, bus.busy_o, bus.ex_mc_cnt_o}), 32'h0);
        chk("rst_pc", bus.new_pc_o, 32'h0);
        @(negedge clk);
        rst = 0;
        cycle(1, 0, 2'b00, 0, 0, 32'h0);
        idle(1);
        cycle(0, 1, 2'b01, 0, 0, 32'h0);
        idle(2);
        cycle(0, 1, 2'b10, 0, 0, 32'h0);
        idle(32);
        cycle(1, 0, 2'b00, 0, 0, 32'h0);
        idle(1);
        cycle(0, 1, 2'b11, 0, 0, 32'h0);
        idle(3);
        cycle(0, 0, 2'b00, 1, 0, 32'h0);
        cycle(0, 1, 2'b01, 0, 0, 32'h0);
        idle(2);
        cycle(0, 1, 2'b00, 0, 0, 32'h0);
        cycle(0, 1, 2'b10, 0, 0, 32'h0);
        idle(9);
        cycle(0, 0, 2'b00, 0, 1, 32'h0000_0020);
        idle(1);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(2) == 0, $urandom_range(3) == 0, 2'($urandom_range(3)),
                  $urandom_range(39) == 0, $urandom_range(59) == 0, $urandom);
        idle(40);
        cycle(0, 1, 2'b10, 0, 0, 32'h0);
        idle(5);
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrun_rst_outs", 32'({bus.stall_o, bus.flush_o, bus.ex_mc_done_o, bus.busy_o, bus.ex_mc_cnt_o}), 32'h0);
        chk("midrun_rst_pc", bus.new_pc_o, 32'h0);
`ifdef PIPE_STALL_PERF_EN
        chk("midrun_rst_perf", bus.perf_id_stall_o | bus.perf_mc_stall_o, 32'h0);
`endif
        act = 0;
        pid = 0;
        pmc = 0;
        @(posedge clk);
        #2;
        rst = 0;
        idle(3);
        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
